// File: rtl/hazard_ctrl_if.sv
// Control bundle between the ID/EX/MEM stages and hazard_ctrl.
// HAZARD_CTRL_PERF_EN adds the stall/flush/freeze counters to the bundle.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_BITS = 5,
    parameter int CNT_BITS      = 32
);
    logic                     id_valid;
    logic [REG_ADDR_BITS-1:0] id_rs1;
    logic [REG_ADDR_BITS-1:0] id_rs2;
    logic [REG_ADDR_BITS-1:0] id_rd;
    logic                     id_reg_write;
    logic                     id_mem_to_reg;
    logic                     branch_taken;
    logic                     dmem_req;
    logic                     dmem_ready;
    logic                     pc_en;
    logic                     ifid_en;
    logic                     idex_en;
    logic                     exmem_en;
    logic                     memwb_en;
    logic                     flush_ifid;
    logic                     flush_idex;
    logic [1:0]               fwd_a;
    logic [1:0]               fwd_b;
    logic                     state;
`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_BITS-1:0]      stall_cnt;
    logic [CNT_BITS-1:0]      flush_cnt;
    logic [CNT_BITS-1:0]      freeze_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_to_reg,
        output branch_taken, dmem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  flush_ifid, flush_idex, fwd_a, fwd_b, state,
        input  stall_cnt, flush_cnt, freeze_cnt
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_to_reg,
        input  branch_taken, dmem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output flush_ifid, flush_idex, fwd_a, fwd_b, state,
        output stall_cnt, flush_cnt, freeze_cnt
    );
`else
    if (CNT_BITS < 1) begin : g_cnt_bits_invalid
    end

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_to_reg,
        output branch_taken, dmem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  flush_ifid, flush_idex, fwd_a, fwd_b, state
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_to_reg,
        input  branch_taken, dmem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output flush_ifid, flush_idex, fwd_a, fwd_b, state
    );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage RV32 pipeline: shadow register footprint,
// stall/flush/freeze and EX forwarding selects. HAZARD_CTRL_PERF_EN adds event counters.
module hazard_ctrl #(
    parameter int REG_ADDR_BITS = 5,
    parameter int CNT_BITS      = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [REG_ADDR_BITS-1:0] X0 = {REG_ADDR_BITS{1'b0}};

    state_t                   state_r;
    logic [REG_ADDR_BITS-1:0] ex_rs1_r, ex_rs2_r, ex_rd_r, mem_rd_r, wb_rd_r;
    logic                     ex_rw_r, ex_load_r, mem_rw_r, wb_rw_r;
    logic                     freeze_s, flush_s, stall_s;
    logic [6:0]               ctl_s;

    // A producer matches a consumer only for a tracked write to a register other than x0.
    function automatic logic hit(input logic wr, input logic [REG_ADDR_BITS-1:0] rd,
                                 input logic [REG_ADDR_BITS-1:0] rs);
        return wr && (rd != X0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_BITS-1:0] rs,
                                           input logic m_rw, input logic [REG_ADDR_BITS-1:0] m_rd,
                                           input logic w_rw, input logic [REG_ADDR_BITS-1:0] w_rd);
        if (hit(m_rw, m_rd, rs)) begin
            return 2'b01;
        end else if (hit(w_rw, w_rd, rs)) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    // Winning action this cycle; reset masks every hazard so outputs show reset values at once.
    always_comb begin
        freeze_s = !rst && bus.dmem_req && !bus.dmem_ready;
        flush_s  = !rst && !freeze_s && bus.branch_taken;
        stall_s  = !rst && !freeze_s && !flush_s && bus.id_valid &&
                   (hit(ex_load_r, ex_rd_r, bus.id_rs1) || hit(ex_load_r, ex_rd_r, bus.id_rs2));
    end

    // Enables {pc, ifid, idex, exmem, memwb} and flushes {ifid, idex}.
    always_comb begin
        ctl_s = 7'b11111_00;
        if (freeze_s) begin
            ctl_s = 7'b00000_00;
        end else if (flush_s) begin
            ctl_s = 7'b11111_11;
        end else if (stall_s) begin
            ctl_s = 7'b00111_01;
        end else begin
            ctl_s = 7'b11111_00;
        end
    end

    // Drive the control bundle; forwarding reads only shadow state so it holds while frozen.
    always_comb begin
        {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
         bus.flush_ifid, bus.flush_idex} = ctl_s;
        bus.fwd_a = fwd_sel(ex_rs1_r, mem_rw_r, mem_rd_r, wb_rw_r, wb_rd_r);
        bus.fwd_b = fwd_sel(ex_rs2_r, mem_rw_r, mem_rd_r, wb_rw_r, wb_rd_r);
        bus.state = (state_r == MEM_WAIT);
    end

    // Shadow pipeline: holds on freeze, EX takes a bubble on flush or load-use stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rs1_r  <= X0;
            ex_rs2_r  <= X0;
            ex_rd_r   <= X0;
            ex_rw_r   <= 1'b0;
            ex_load_r <= 1'b0;
            mem_rd_r  <= X0;
            mem_rw_r  <= 1'b0;
            wb_rd_r   <= X0;
            wb_rw_r   <= 1'b0;
        end else if (!freeze_s) begin
            mem_rd_r <= ex_rd_r;
            mem_rw_r <= ex_rw_r;
            wb_rd_r  <= mem_rd_r;
            wb_rw_r  <= mem_rw_r;
            if (flush_s || stall_s) begin
                ex_rs1_r  <= X0;
                ex_rs2_r  <= X0;
                ex_rd_r   <= X0;
                ex_rw_r   <= 1'b0;
                ex_load_r <= 1'b0;
            end else begin
                ex_rs1_r  <= bus.id_rs1;
                ex_rs2_r  <= bus.id_rs2;
                ex_rd_r   <= bus.id_rd;
                ex_rw_r   <= bus.id_reg_write && bus.id_valid;
                ex_load_r <= bus.id_mem_to_reg && bus.id_valid;
            end
        end
    end

    // RUN/MEM_WAIT tracker: MEM_WAIT follows every frozen cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN:      state_r <= freeze_s ? MEM_WAIT : RUN;
                MEM_WAIT: state_r <= freeze_s ? MEM_WAIT : RUN;
                default:  state_r <= RUN;
            endcase
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic [CNT_BITS-1:0] stall_cnt_r, flush_cnt_r, freeze_cnt_r;

    // Saturating counts of the winning action per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r  <= {CNT_BITS{1'b0}};
            flush_cnt_r  <= {CNT_BITS{1'b0}};
            freeze_cnt_r <= {CNT_BITS{1'b0}};
        end else begin
            if (stall_s && stall_cnt_r != CNT_MAX)   stall_cnt_r  <= stall_cnt_r + CNT_ONE;
            if (flush_s && flush_cnt_r != CNT_MAX)   flush_cnt_r  <= flush_cnt_r + CNT_ONE;
            if (freeze_s && freeze_cnt_r != CNT_MAX) freeze_cnt_r <= freeze_cnt_r + CNT_ONE;
        end
    end

    assign bus.stall_cnt  = stall_cnt_r;
    assign bus.flush_cnt  = flush_cnt_r;
    assign bus.freeze_cnt = freeze_cnt_r;
`else
    if (CNT_BITS < 1) begin : g_cnt_bits_invalid
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expected control words queued at stimulus time.
module tb_hazard_ctrl;
    localparam int RA = 5;
    localparam logic [6:0] C_NORM  = 7'b11111_00;
    localparam logic [6:0] C_STALL = 7'b00111_01;
    localparam logic [6:0] C_FLUSH = 7'b11111_11;
    localparam logic [6:0] C_FRZ   = 7'b00000_00;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t        sb[$];
    logic [11:0] got_q[$];

    hazard_ctrl_if #(.REG_ADDR_BITS(RA), .CNT_BITS(32)) bus ();

    hazard_ctrl #(.REG_ADDR_BITS(RA), .CNT_BITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.flush_ifid, bus.flush_idex, bus.fwd_a, bus.fwd_b, bus.state};
    endfunction

    function automatic logic [11:0] ev(input logic [6:0] ctl, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic st);
        return {ctl, fa, fb, st};
    endfunction

    task automatic drive(input logic v, input logic [RA-1:0] rs1, input logic [RA-1:0] rs2,
                         input logic [RA-1:0] rd, input logic rw, input logic ld,
                         input logic br, input logic req, input logic rdy);
        bus.id_valid      = v;
        bus.id_rs1        = rs1;
        bus.id_rs2        = rs2;
        bus.id_rd         = rd;
        bus.id_reg_write  = rw;
        bus.id_mem_to_reg = ld;
        bus.branch_taken  = br;
        bus.dmem_req      = req;
        bus.dmem_ready    = rdy;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        nop();
        repeat (n) @(negedge clk);
    endtask

    // Queue the expectation, sample mid-cycle, advance to the next negedge.
    task automatic step(input string tag, input logic [11:0] exp);
        sb.push_back('{tag, exp});
        #2;
        got_q.push_back(obs());
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("reset_vals", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        rst = 1'b0;
        idle(3);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [11:0] g = got_q.pop_front();
            checks++;
            if (g !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.tag, g, e.exp); end
        end
    endtask

    task automatic test_load_use();
        idle(3);
        drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step("lu_load", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("lu_stall", ev(C_STALL, 2'b00, 2'b00, 1'b0));
        step("lu_resume", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        nop();
        step("lu_fwd_wb", ev(C_NORM, 2'b10, 2'b00, 1'b0));
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [11:0] g = got_q.pop_front();
            checks++;
            if (g !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.tag, g, e.exp); end
        end
    endtask

    task automatic test_back_to_back();
        idle(3);
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("b2b_c0", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("b2b_c1", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        nop();
        step("b2b_fwd_mem", ev(C_NORM, 2'b00, 2'b01, 1'b0));
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("b2b_c3", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd1, 5'd1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("b2b_c4", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd4, 5'd9, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("b2b_c5", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        nop();
        step("b2b_fwd_wb", ev(C_NORM, 2'b00, 2'b10, 1'b0));
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step("x0_load", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("x0_no_stall", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        nop();
        step("x0_no_fwd_mem", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        step("x0_no_fwd_wb", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [11:0] g = got_q.pop_front();
            checks++;
            if (g !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.tag, g, e.exp); end
        end
    endtask

    task automatic test_double_hazard();
        idle(3);
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("dh_c0", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        step("dh_c1", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("dh_c2", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        nop();
        step("dh_mem_prio", ev(C_NORM, 2'b01, 2'b01, 1'b0));
        step("dh_clear", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [11:0] g = got_q.pop_front();
            checks++;
            if (g !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.tag, g, e.exp); end
        end
    endtask

    task automatic test_branch_load_use();
        idle(3);
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step("bl_load", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step("bl_flush", ev(C_FLUSH, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("bl_no_stall", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [11:0] g = got_q.pop_front();
            checks++;
            if (g !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.tag, g, e.exp); end
        end
    endtask

    task automatic test_mem_wait();
        idle(3);
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("mw_c0", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("mw_c1", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mw_frz1", ev(C_FRZ, 2'b01, 2'b00, 1'b0));
        step("mw_frz2", ev(C_FRZ, 2'b01, 2'b00, 1'b1));
        step("mw_frz3", ev(C_FRZ, 2'b01, 2'b00, 1'b1));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("mw_ready_flush", ev(C_FLUSH, 2'b01, 2'b00, 1'b1));
        nop();
        step("mw_run", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [11:0] g = got_q.pop_front();
            checks++;
            if (g !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.tag, g, e.exp); end
        end
    endtask

    task automatic test_reset_mid_freeze();
        idle(3);
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step("rf_load", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rf_frz1", ev(C_FRZ, 2'b00, 2'b00, 1'b0));
        step("rf_frz2", ev(C_FRZ, 2'b00, 2'b00, 1'b1));
        #1;
        rst = 1'b1;
        step("rf_async_rst", ev(C_NORM, 2'b00, 2'b00, 1'b0));
`ifdef HAZARD_CTRL_PERF_EN
        checks++;
        if ({bus.stall_cnt, bus.flush_cnt, bus.freeze_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL rf_perf_clear got=%h/%h/%h exp=0", bus.stall_cnt, bus.flush_cnt, bus.freeze_cnt);
        end
`endif
        rst = 1'b0;
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rf_post_normal", ev(C_NORM, 2'b00, 2'b00, 1'b0));
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [11:0] g = got_q.pop_front();
            checks++;
            if (g !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.tag, g, e.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_double_hazard();
        test_branch_load_use();
        test_mem_wait();
        test_reset_mid_freeze();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
